booth_mul_seq: RTL and testbench



---
 rtl/booth_mul_seq_if.sv | 24 ++
 rtl/booth_mul_seq.sv | 93 +++++++++
 tb/tb_booth_mul_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_seq_if.sv
// rtl/booth_mul_seq_if.sv - start/done handshake bundle for the sequential Booth multiplier
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     mcnd;
    logic [WIDTH-1:0]     mplr;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    // Control unit side: issues operations and waits on done.
    modport master (
        output start, is_signed, mcnd, mplr,
        input  busy, done, product
    );

    // Multiplier side.
    modport slave (
        input  start, is_signed, mcnd, mplr,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - iterative radix-4 Booth multiplier, one digit per clock
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    booth_mul_seq_if.slave bus
);
    // Operands are carried as WIDTH+2 bits so the unsigned top bit gets its own digit;
    // the accumulator is 2*WIDTH+2 bits and wraps modulo its width.
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] LAST_SIGNED   = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] LAST_UNSIGNED = CW'(WIDTH / 2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   mc_sh;     // extended multiplicand, pre-shifted to weight 4^k
    logic [EW-1:0]   mp_sh;     // extended multiplier, current digit in bits [1:0]
    logic            mp_prev;   // bit below the current digit (m[2k-1])
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            sgn;

    logic [AW-1:0]   pp;
    logic [AW-1:0]   acc_next;
    logic            last_digit;

    // Booth recoding of the current triplet into a partial product.
    always_comb begin
        pp = '0;
        case ({mp_sh[1:0], mp_prev})
            3'b001, 3'b010: pp = mc_sh;
            3'b011:         pp = {mc_sh[AW-2:0], 1'b0};
            3'b100:         pp = '0 - {mc_sh[AW-2:0], 1'b0};
            3'b101, 3'b110: pp = '0 - mc_sh;
            default:        pp = '0;
        endcase
        acc_next   = acc + pp;
        last_digit = (cnt == (sgn ? LAST_SIGNED : LAST_UNSIGNED));
    end

    // Control FSM and datapath: latch on start, retire one digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
            acc         <= '0;
            cnt         <= '0;
            mc_sh       <= '0;
            mp_sh       <= '0;
            mp_prev     <= 1'b0;
            sgn         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mc_sh    <= {{(AW - WIDTH){bus.is_signed & bus.mcnd[WIDTH-1]}}, bus.mcnd};
                        mp_sh    <= {{2{bus.is_signed & bus.mplr[WIDTH-1]}}, bus.mplr};
                        mp_prev  <= 1'b0;
                        sgn      <= bus.is_signed;
                        acc      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    mc_sh   <= {mc_sh[AW-3:0], 2'b00};
                    mp_sh   <= {{2{mp_sh[EW-1]}}, mp_sh[EW-1:2]};
                    mp_prev <= mp_sh[1];
                    cnt     <= cnt + CW'(1);
                    if (last_digit) begin
                        bus.product <= acc_next[2*WIDTH-1:0];
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - scoreboard bench for booth_mul_seq at WIDTH 32 and 8
module tb_booth_mul_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset32;
    logic reset8;

    booth_mul_seq_if #(.WIDTH(32)) bus32();
    booth_mul_seq_if #(.WIDTH(8))  bus8();

    booth_mul_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset32), .bus(bus32));
    booth_mul_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8),  .bus(bus8));

    typedef struct {
        logic [63:0] prod;
        int          start_edge;
        int          n;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int busy_cnt32 = 0;
    int busy_cnt8  = 0;
    logic [63:0] held32 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: extend each operand to the product width and multiply; the low
    // bits of that product are the exact signed or unsigned result.
    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] r;
        ea = s ? {{8{a[7]}}, a} : {8'b0, a};
        eb = s ? {{8{b[7]}}, b} : {8'b0, b};
        r  = ea * eb;
        return {48'b0, r};
    endfunction

    // Monitor: samples both DUTs 1 time unit after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (reset32) begin
            check("reset_busy32", 64'(bus32.busy), 64'd0);
            check("reset_done32", 64'(bus32.done), 64'd0);
            check("reset_product32", bus32.product, 64'd0);
            busy_cnt32 = 0;
            held32 = '0;
        end else begin
            if (bus32.busy) busy_cnt32++;
            if (bus32.done) begin
                if (q32.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done32: got done=1 expected no pending operation at cycle %0d", cyc);
                end else begin
                    e = q32.pop_front();
                    check("product32", bus32.product, e.prod);
                    check("latency32", 64'(cyc - e.start_edge), 64'(e.n));
                    check("busy_cycles32", 64'(busy_cnt32), 64'(e.n));
                    held32 = e.prod;
                end
                busy_cnt32 = 0;
            end else if (bus32.busy) begin
                check("held_product32", bus32.product, held32);
            end
        end
        if (reset8) begin
            busy_cnt8 = 0;
        end else begin
            if (bus8.busy) busy_cnt8++;
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done8: got done=1 expected no pending operation at cycle %0d", cyc);
                end else begin
                    e = q8.pop_front();
                    check("product8", 64'(bus8.product), e.prod);
                    check("latency8", 64'(cyc - e.start_edge), 64'(e.n));
                    check("busy_cycles8", 64'(busy_cnt8), 64'(e.n));
                end
                busy_cnt8 = 0;
            end
        end
    end

    // Issue one operation once the DUT is idle; operands are scrambled right after
    // the start edge so any late sampling of the inputs shows up as a wrong product.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
        int guard = 0;
        @(negedge clk);
        while (bus32.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout32: got busy=1 for %0d cycles expected idle", guard);
            return;
        end
        bus32.start     = 1'b1;
        bus32.mcnd      = a;
        bus32.mplr      = b;
        bus32.is_signed = s;
        if (push) q32.push_back('{ref32(a, b, s), cyc + 1, s ? 16 : 17});
        @(negedge clk);
        bus32.start     = 1'b0;
        bus32.mcnd      = $urandom;
        bus32.mplr      = $urandom;
        bus32.is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int guard = 0;
        @(negedge clk);
        while (bus8.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout8: got busy=1 for %0d cycles expected idle", guard);
            return;
        end
        bus8.start     = 1'b1;
        bus8.mcnd      = a;
        bus8.mplr      = b;
        bus8.is_signed = s;
        q8.push_back('{ref8(a, b, s), cyc + 1, s ? 4 : 5});
        @(negedge clk);
        bus8.start     = 1'b0;
        bus8.mcnd      = 8'($urandom);
        bus8.mplr      = 8'($urandom);
        bus8.is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic stim32();
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        issue32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        issue32(32'd7,         32'hFFFF_FFFD, 1'b1, 1'b1);
        issue32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        issue32(32'd0,         32'hFFFF_FFFF, 1'b1, 1'b1);
        // Start during RUN must be ignored; the next issue lands in the done cycle.
        issue32(32'd3, 32'd5, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        bus32.start = 1'b1;
        bus32.mcnd  = 32'd9;
        bus32.mplr  = 32'd9;
        @(negedge clk);
        bus32.start = 1'b0;
        issue32(32'd9, 32'd9, 1'b1, 1'b1);
        // Abort mid-operation: no done pulse may follow.
        issue32(32'd1000, 32'd1000, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        reset32 = 1'b1;
        @(negedge clk);
        reset32 = 1'b0;
        repeat (25) @(negedge clk);
        issue32(32'd1000, 32'd1000, 1'b0, 1'b1);
        repeat (300) issue32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic stim8();
        logic [7:0] corners [5];
        corners[0] = 8'h00;
        corners[1] = 8'h01;
        corners[2] = 8'h7F;
        corners[3] = 8'h80;
        corners[4] = 8'hFF;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    issue8(corners[i], corners[j], 1'(s));
        repeat (1500) issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got cycle %0d expected completion before 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        reset32 = 1'b1;
        reset8  = 1'b1;
        bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.mcnd = '0; bus32.mplr = '0;
        bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.mcnd  = '0; bus8.mplr  = '0;
        repeat (3) @(negedge clk);
        reset32 = 1'b0;
        reset8  = 1'b0;
        fork
            stim32();
            stim8();
        join
        guard = 0;
        while ((q32.size() != 0 || q8.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q32.size(), q8.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
